// File: rtl/vid_timing_sched.sv
// vid_timing_sched: raster sequencer that turns the frame-latched timing
// configuration into pixel-divided h/v counters, registered sync/blank
// decode, and one line-fetch request per displayed line.
module vid_timing_sched #(
  parameter int TW = 13,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [5:0]    pcnt,
  input  logic [TW-1:0] hsize,
  input  logic [TW-1:0] hend,
  input  logic [TW-1:0] hsync_start,
  input  logic [TW-1:0] hsync_end,
  input  logic [TW-1:0] vsize,
  input  logic [TW-1:0] vend,
  input  logic [TW-1:0] vsync_start,
  input  logic [TW-1:0] vsync_end,
  input  logic [AW-1:0] base_address,
  input  logic [AW-1:0] lineinc,
  input  logic          fetch_ack,
  output logic [TW-1:0] hcnt,
  output logic [TW-1:0] vcnt,
  output logic          hsync,
  output logic          hblank,
  output logic          vsync,
  output logic          vblank,
  output logic          pix_valid,
  output logic          frame_start,
  output logic          fetch_req,
  output logic [AW-1:0] fetch_addr,
  output logic          fetch_ovf
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [TW:0] W_ONE = {{TW{1'b0}}, 1'b1};

  state_t state, state_next;

  logic [5:0]    sh_pcnt;
  logic [TW-1:0] sh_hsize, sh_hend, sh_hss, sh_hse;
  logic [TW-1:0] sh_vsize, sh_vend, sh_vss, sh_vse;
  logic [AW-1:0] sh_base, sh_inc;

  logic [5:0]    div;
  logic [AW-1:0] line_addr;
  logic [TW:0]   hcnt_inc, vcnt_inc;
  logic          pix_tick, line_end, frame_end, start_frame, decode_on;
  logic          line0_due, line_due, fetch_due;
  logic [AW-1:0] due_addr;

  assign hcnt_inc  = {1'b0, hcnt} + W_ONE;
  assign vcnt_inc  = {1'b0, vcnt} + W_ONE;
  assign pix_tick  = (state == ACTIVE) && (div == sh_pcnt);
  assign line_end  = pix_tick && (hcnt == sh_hend);
  assign frame_end = line_end && (vcnt == sh_vend);
  assign decode_on = (state == ACTIVE) && (state_next == ACTIVE);

  // Line 0 uses the configuration being latched this clock; later lines use the shadow copy.
  assign line0_due = start_frame && (hsize != '0) && (vsize != '0);
  assign line_due  = pix_tick && !line_end && (hcnt_inc == {1'b0, sh_hsize})
                     && (vcnt_inc < {1'b0, sh_vsize});
  assign fetch_due = line0_due || line_due;
  assign due_addr  = line0_due ? base_address : line_addr + sh_inc;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: start on enable, and at each frame end either restart or stop.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next  = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (frame_end) begin
          if (en) start_frame = 1'b1;
          else    state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow configuration, refreshed only at a frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_pcnt  <= '0;
      sh_hsize <= '0;
      sh_hend  <= '0;
      sh_hss   <= '0;
      sh_hse   <= '0;
      sh_vsize <= '0;
      sh_vend  <= '0;
      sh_vss   <= '0;
      sh_vse   <= '0;
      sh_base  <= '0;
      sh_inc   <= '0;
    end else if (start_frame) begin
      sh_pcnt  <= pcnt;
      sh_hsize <= hsize;
      sh_hend  <= hend;
      sh_hss   <= hsync_start;
      sh_hse   <= hsync_end;
      sh_vsize <= vsize;
      sh_vend  <= vend;
      sh_vss   <= vsync_start;
      sh_vse   <= vsync_end;
      sh_base  <= base_address;
      sh_inc   <= lineinc;
    end
  end

  // Pixel divider and raster counters; the vend wrap is covered by the frame restart/stop path.
  always_ff @(posedge clk) begin
    if (reset || start_frame || state_next == IDLE) begin
      div  <= '0;
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_tick) begin
      div <= '0;
      if (line_end) begin
        hcnt <= '0;
        vcnt <= vcnt_inc[TW-1:0];
      end else begin
        hcnt <= hcnt_inc[TW-1:0];
      end
    end else begin
      div <= div + 6'd1;
    end
  end

  // Registered decode of the current counter position.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= 1'b0;
      hblank      <= 1'b0;
      vsync       <= 1'b0;
      vblank      <= 1'b0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= decode_on && (hcnt >= sh_hss) && (hcnt < sh_hse);
      hblank      <= decode_on && (hcnt >= sh_hsize);
      vsync       <= decode_on && (vcnt >= sh_vss) && (vcnt < sh_vse);
      vblank      <= decode_on && (vcnt >= sh_vsize);
      pix_valid   <= decode_on && pix_tick && (hcnt < sh_hsize) && (vcnt < sh_vsize);
      frame_start <= start_frame;
    end
  end

  // Fetch request handshake: one pending request, overflow flagged when another comes due.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_req  <= 1'b0;
      fetch_addr <= '0;
      fetch_ovf  <= 1'b0;
      line_addr  <= '0;
    end else begin
      if (start_frame)   line_addr <= base_address;
      else if (line_due) line_addr <= due_addr;

      if (fetch_due && (!fetch_req || fetch_ack)) begin
        fetch_req  <= 1'b1;
        fetch_addr <= due_addr;
      end else begin
        if (fetch_due) fetch_ovf <= 1'b1;
        if (fetch_req && fetch_ack) begin
          fetch_req  <= 1'b0;
          fetch_addr <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vid_timing_sched.sv
// tb_vid_timing_sched: directed and randomized stimulus for vid_timing_sched,
// checked every clock against a raster model derived from elapsed clocks.
module tb_vid_timing_sched;
  localparam int TW = 13;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic [5:0]    pcnt = '0;
  logic [TW-1:0] hsize = '0, hend = '0, hsync_start = '0, hsync_end = '0;
  logic [TW-1:0] vsize = '0, vend = '0, vsync_start = '0, vsync_end = '0;
  logic [AW-1:0] base_address = '0, lineinc = '0;
  logic          fetch_ack = 1'b0;
  logic [TW-1:0] hcnt, vcnt;
  logic          hsync, hblank, vsync, vblank, pix_valid, frame_start, fetch_req, fetch_ovf;
  logic [AW-1:0] fetch_addr;

  vid_timing_sched #(.TW(TW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .en(en), .pcnt(pcnt),
    .hsize(hsize), .hend(hend), .hsync_start(hsync_start), .hsync_end(hsync_end),
    .vsize(vsize), .vend(vend), .vsync_start(vsync_start), .vsync_end(vsync_end),
    .base_address(base_address), .lineinc(lineinc), .fetch_ack(fetch_ack),
    .hcnt(hcnt), .vcnt(vcnt), .hsync(hsync), .hblank(hblank), .vsync(vsync),
    .vblank(vblank), .pix_valid(pix_valid), .frame_start(frame_start),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ovf(fetch_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned pcnt, hsize, hend, hss, hse, vsize, vend, vss, vse;
    logic [31:0] base, inc;
  } cfg_t;

  // Model: frame configuration plus clocks elapsed since frame start.
  bit          m_act = 1'b0;
  int unsigned m_t = 0;
  cfg_t        m_cfg;
  int unsigned e_hcnt = 0, e_vcnt = 0;
  bit          e_hs = 0, e_hb = 0, e_vs = 0, e_vb = 0, e_pv = 0, e_fs = 0, e_req = 0, e_ovf = 0;
  logic [31:0] e_addr = '0;

  int vectors = 0;
  int miscompares = 0;
  int ack_mode = 1;  // 0: never ack, 1: ack the clock after a request, 2: random

  function automatic cfg_t cur_inputs();
    cfg_t c;
    c.pcnt = 32'(pcnt);   c.hsize = 32'(hsize); c.hend = 32'(hend);
    c.hss = 32'(hsync_start); c.hse = 32'(hsync_end);
    c.vsize = 32'(vsize); c.vend = 32'(vend);
    c.vss = 32'(vsync_start); c.vse = 32'(vsync_end);
    c.base = base_address; c.inc = lineinc;
    return c;
  endfunction

  task automatic model_edge();
    cfg_t c, nc;
    int unsigned per, pk, ph, pv, flen, nt;
    bit ptick, start, nact, l0, ld, due, run;
    logic [31:0] daddr;
    if (reset) begin
      m_act = 0; m_t = 0; m_cfg = cur_inputs();
      m_cfg = '{default: 0};
      e_hcnt = 0; e_vcnt = 0; e_hs = 0; e_hb = 0; e_vs = 0; e_vb = 0;
      e_pv = 0; e_fs = 0; e_req = 0; e_ovf = 0; e_addr = '0;
    end else begin
      c     = m_cfg;
      per   = c.pcnt + 1;
      pk    = m_t / per;
      ph    = pk % (c.hend + 1);
      pv    = pk / (c.hend + 1);
      ptick = m_act && (m_t % per == per - 1);
      flen  = per * (c.hend + 1) * (c.vend + 1);
      start = 0; nact = m_act; nt = m_t; nc = c;
      if (!m_act) start = en;
      else if (m_t == flen - 1) begin
        if (en) start = 1; else nact = 0;
      end else nt = m_t + 1;
      if (start) begin nact = 1; nt = 0; nc = cur_inputs(); end
      run  = m_act && nact;
      e_hs = run && ph >= c.hss && ph < c.hse;
      e_hb = run && ph >= c.hsize;
      e_vs = run && pv >= c.vss && pv < c.vse;
      e_vb = run && pv >= c.vsize;
      e_pv = run && ptick && ph < c.hsize && pv < c.vsize;
      e_fs = start;
      l0 = start && nc.hsize != 0 && nc.vsize != 0;
      ld = ptick && ph + 1 == c.hsize && ph != c.hend && pv + 1 < c.vsize;
      daddr = l0 ? nc.base : c.base + c.inc * 32'(pv + 1);
      due = l0 || ld;
      if (due && (!e_req || fetch_ack)) begin
        e_req = 1; e_addr = daddr;
      end else begin
        if (due) e_ovf = 1;
        if (e_req && fetch_ack) begin e_req = 0; e_addr = '0; end
      end
      m_act = nact; m_t = nt; m_cfg = nc;
      if (m_act) begin
        per = nc.pcnt + 1;
        pk  = m_t / per;
        e_hcnt = pk % (nc.hend + 1);
        e_vcnt = pk / (nc.hend + 1);
      end else begin
        e_hcnt = 0; e_vcnt = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("hcnt", 32'(hcnt), e_hcnt);
    chk("vcnt", 32'(vcnt), e_vcnt);
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("hblank", 32'(hblank), 32'(e_hb));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("vblank", 32'(vblank), 32'(e_vb));
    chk("pix_valid", 32'(pix_valid), 32'(e_pv));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("fetch_req", 32'(fetch_req), 32'(e_req));
    chk("fetch_addr", fetch_addr, e_addr);
    chk("fetch_ovf", 32'(fetch_ovf), 32'(e_ovf));
    if (ack_mode == 0)      fetch_ack = 1'b0;
    else if (ack_mode == 1) fetch_ack = e_req;
    else                    fetch_ack = 1'($urandom_range(0, 1));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_cfg(input int unsigned p, hs, he, hss, hse, vs, ve, vss, vse,
                         input logic [31:0] b, inc);
    pcnt = 6'(p); hsize = TW'(hs); hend = TW'(he);
    hsync_start = TW'(hss); hsync_end = TW'(hse);
    vsize = TW'(vs); vend = TW'(ve); vsync_start = TW'(vss); vsync_end = TW'(vse);
    base_address = b; lineinc = inc;
  endtask

  task automatic rand_cfg();
    set_cfg($urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 7),
            $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 7),
            $urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom, $urandom);
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 15) == 0) rand_cfg();
      if ($urandom_range(0, 63) == 0) en = ~en;
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1; step(); reset = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    m_cfg = '{default: 0};
    // Reset, then idle with outputs held low.
    run(3);
    reset = 1'b0;
    run(3);
    // Base timing, pcnt=0: 24-clock frames, two fetches per frame.
    set_cfg(0, 4, 5, 4, 5, 2, 3, 2, 3, 32'h1000, 32'h40);
    ack_mode = 1;
    en = 1'b1;
    run(60);
    // pcnt=2 mid-frame: takes effect on the next frame, 72-clock frames.
    pcnt = 6'd2;
    run(170);
    // Ack withheld: request stays pending and overflow is flagged.
    ack_mode = 0;
    run(80);
    // Reset with a request pending.
    reset = 1'b1; en = 1'b0;
    run(1);
    reset = 1'b0;
    run(3);
    // Enable drop mid-frame after a mid-frame hsize change.
    ack_mode = 1; pcnt = 6'd0; en = 1'b1;
    run(30);
    hsize = TW'(2);
    run(10);
    en = 1'b0;
    run(40);
    // hend=0 and zero-size corner cases.
    set_cfg(1, 1, 0, 0, 1, 3, 4, 1, 2, 32'hFFFF_FFC0, 32'h40);
    en = 1'b1;
    run(40);
    set_cfg(0, 0, 3, 1, 2, 2, 2, 0, 1, 32'h2000, 32'h10);
    run(40);
    set_cfg(0, 3, 3, 1, 2, 0, 2, 0, 1, 32'h3000, 32'h10);
    run(40);
    // Randomized segments.
    for (int s = 0; s < 30; s++) begin
      rand_cfg();
      ack_mode = $urandom_range(0, 5) == 0 ? 0 : int'($urandom_range(1, 2));
      en = 1'b1;
      run_rand(120);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
